// File: rtl/descrypt_batch_ctrl_if.sv
// Signal bundle between the batch controller and its environment: key
// stream from the key generator, core drive/return, and the hash stream
// toward the comparator. The controller takes the slave view.
interface descrypt_batch_ctrl_if #(
    parameter int SALT_W = 12,
    parameter int HASH_W = 64
);
    logic [55:0]       key56_in;
    logic              key_valid;
    logic              key_rdy;
    logic [SALT_W-1:0] salt_in;

    logic [55:0]       core_key56;
    logic [SALT_W-1:0] core_salt;
    logic              core_valid;
    logic              START_CRYPT;
    logic              ENABLE_CRYPT;
    logic [HASH_W-1:0] core_hash;
    logic              core_valid_out;

    logic [HASH_W-1:0] hash_out;
    logic [3:0]        hash_slot;
    logic              hash_valid;
    logic              hash_rdy;
    logic              busy;

    modport master (
        output key56_in, key_valid, salt_in, core_hash, core_valid_out, hash_rdy,
        input  key_rdy, core_key56, core_salt, core_valid, START_CRYPT, ENABLE_CRYPT,
               hash_out, hash_slot, hash_valid, busy
    );

    modport slave (
        input  key56_in, key_valid, salt_in, core_hash, core_valid_out, hash_rdy,
        output key_rdy, core_key56, core_salt, core_valid, START_CRYPT, ENABLE_CRYPT,
               hash_out, hash_slot, hash_valid, busy
    );
endinterface

// File: rtl/descrypt_batch_ctrl.sv
// Batch sequencer for the 16-slot recirculating descrypt core: loads up to
// 16 keys, lets them recirculate ITERATIONS passes, captures the results
// into a 16-entry FIFO tagged with their slot index.
//
// state | meaning
// IDLE  | core disabled, waiting for a key with the result FIFO empty
// LOAD  | cnt 0..15, one key (or padding) per slot, START_CRYPT high
// RUN   | core recirculating; last 16 cycles form the capture window
module descrypt_batch_ctrl #(
    parameter int ITERATIONS = 25,
    parameter int SALT_W     = 12,
    parameter int HASH_W     = 64
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    descrypt_batch_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(16 * ITERATIONS + 16);
    localparam logic [CNT_W-1:0] CNT_LOAD_LAST = CNT_W'(15);
    // Overlap decision is taken on the edge that would open the window.
    localparam logic [CNT_W-1:0] CNT_WIN_PRE   = CNT_W'(16 * ITERATIONS - 1);
    localparam logic [CNT_W-1:0] CNT_WIN_LAST  = CNT_W'(16 * ITERATIONS + 15);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cap_q, cap_d;
    logic              salt_ld;
    logic [SALT_W-1:0] salt_q;

    logic [HASH_W+3:0] fifo_mem [16];
    logic [3:0]        wr_ptr, rd_ptr;
    logic [4:0]        fifo_cnt;
    logic              fifo_empty;
    logic              push, pop;
    logic              overlap_ok;

    assign fifo_empty = (fifo_cnt == 5'd0);
    // The window index is cnt[3:0] both in RUN (cnt=16*ITERATIONS+k) and in
    // an overlapped LOAD (cnt=k), since 16*ITERATIONS is a multiple of 16.
    assign push       = cap_q && bus.core_valid_out && (fifo_cnt != 5'd16);
    assign pop        = bus.hash_valid && bus.hash_rdy;
    // Salt must match: the old slots still need the latched salt to finish.
    assign overlap_ok = bus.key_valid && fifo_empty && (bus.salt_in == salt_q);

    // State, counter and capture-window registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
        end
    end

    // Next-state, counter and capture-window control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        cap_d   = cap_q;
        salt_ld = 1'b0;
        if (cap_q && (cnt_q[3:0] == 4'hF)) begin
            cap_d = 1'b0;
        end
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bus.key_valid && fifo_empty) begin
                    state_d = ST_LOAD;
                    salt_ld = 1'b1;
                end
            end
            ST_LOAD: begin
                if (cnt_q == CNT_LOAD_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_WIN_PRE) begin
                    cap_d = 1'b1;
                    if (overlap_ok) begin
                        state_d = ST_LOAD;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == CNT_WIN_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Batch salt is latched only when a batch starts from IDLE.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            salt_q <= '0;
        end else if (salt_ld) begin
            salt_q <= bus.salt_in;
        end
    end

    // Result FIFO storage; contents are only observed while non-empty.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {bus.core_hash, cnt_q[3:0]};
        end
    end

    // Result FIFO pointers and occupancy.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 4'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 4'd1;
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 5'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 5'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign bus.key_rdy      = (state_q == ST_LOAD);
    assign bus.START_CRYPT  = (state_q == ST_LOAD);
    assign bus.ENABLE_CRYPT = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign bus.core_valid   = (state_q == ST_LOAD) && bus.key_valid;
    assign bus.core_key56   = bus.key56_in;
    assign bus.core_salt    = salt_q;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.hash_valid   = !fifo_empty;
    assign bus.hash_out     = fifo_empty ? '0 : fifo_mem[rd_ptr][HASH_W+3:4];
    assign bus.hash_slot    = fifo_empty ? 4'd0 : fifo_mem[rd_ptr][3:0];

endmodule

// File: tb/tb_descrypt_batch_ctrl.sv
// Bench for descrypt_batch_ctrl: a delay-line stand-in for the descrypt
// core, directed key batches, and a scoreboard drained by a monitor.
module tb_descrypt_batch_ctrl;

    localparam int IT = 25;
    localparam int L  = 16 * IT;

    logic   CLK = 1'b0;
    logic   RESET_N = 1'b0;
    longint cyc = 0;
    int     checks = 0;
    int     errors = 0;

    typedef struct {
        logic [63:0] hash;
        logic [3:0]  slot;
        longint      when;
    } exp_t;
    exp_t sbq[$];

    descrypt_batch_ctrl_if #(.SALT_W(12), .HASH_W(64)) bus ();

    descrypt_batch_ctrl #(.ITERATIONS(IT), .SALT_W(12), .HASH_W(64)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [63:0] hfun(input logic [55:0] k, input logic [11:0] s);
        return {k, s[11:4]} ^ {s, 52'd0} ^ 64'h9e37_79b9_7f4a_7c15;
    endfunction

    // Core stand-in: a slot loaded in cycle c appears on the outputs in cycle c+L.
    logic        pv [L];
    logic [55:0] pk [L];
    logic [11:0] ps [L];
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < L; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= bus.START_CRYPT & bus.ENABLE_CRYPT & bus.core_valid;
            pk[0] <= bus.core_key56;
            ps[0] <= bus.core_salt;
            for (int i = 1; i < L; i++) begin
                pv[i] <= pv[i-1];
                pk[i] <= pk[i-1];
                ps[i] <= ps[i-1];
            end
        end
    end
    assign bus.core_valid_out = pv[L-1];
    assign bus.core_hash      = hfun(pk[L-1], ps[L-1]);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input longint target);
        while (cyc < target) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_key_rdy"}, 64'(bus.key_rdy), 0);
        check({tag, "_start"}, 64'(bus.START_CRYPT), 0);
        check({tag, "_enable"}, 64'(bus.ENABLE_CRYPT), 0);
        check({tag, "_core_valid"}, 64'(bus.core_valid), 0);
        check({tag, "_core_salt"}, 64'(bus.core_salt), 0);
        check({tag, "_hash_out"}, bus.hash_out, 0);
        check({tag, "_hash_slot"}, 64'(bus.hash_slot), 0);
        check({tag, "_hash_valid"}, 64'(bus.hash_valid), 0);
        check({tag, "_busy"}, 64'(bus.busy), 0);
    endtask

    // Offer a batch: wait for LOAD, then drive 16 slots; mask bit k marks slot k as a real key.
    task automatic run_batch(input logic [15:0] mask, input logic [55:0] base,
                             input logic [11:0] salt, input bit timed, output longint ls);
        bit          got;
        logic [55:0] key;
        exp_t        e;
        got = 1'b0;
        bus.key56_in  = base;
        bus.key_valid = 1'b1;
        bus.salt_in   = salt;
        for (int n = 0; n < 1000 && !got; n++) begin
            @(posedge CLK);
            #1;
            if (bus.key_rdy) got = 1'b1;
        end
        ls = cyc;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL load_start_timeout: key_rdy never rose, required 1");
            bus.key_valid = 1'b0;
            return;
        end
        for (int k = 0; k < 16; k++) begin
            key = base + 56'(k);
            bus.key56_in  = key;
            bus.key_valid = mask[k];
            #1;
            check("load_key_rdy", 64'(bus.key_rdy), 1);
            check("load_start", 64'(bus.START_CRYPT), 1);
            check("load_core_valid", 64'(bus.core_valid), 64'(mask[k]));
            check("load_core_key", 64'(bus.core_key56), 64'(key));
            check("load_core_salt", 64'(bus.core_salt), 64'(salt));
            @(posedge CLK);
            if (mask[k]) begin
                e.hash = hfun(key, salt);
                e.slot = 4'(k);
                e.when = timed ? ls + L + 1 + k : -1;
                sbq.push_back(e);
            end
            #1;
        end
        bus.key_valid = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every output handshake, and checks the head holds still while stalled.
    initial begin
        exp_t        e;
        bit          hold = 1'b0;
        logic [63:0] ph;
        logic [3:0]  pslot;
        forever begin
            @(negedge CLK);
            if (RESET_N && bus.hash_valid) begin
                if (hold) begin
                    check("hold_hash", bus.hash_out, ph);
                    check("hold_slot", 64'(bus.hash_slot), 64'(pslot));
                end
                if (bus.hash_rdy) begin
                    hold = 1'b0;
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_hash: got slot %0d hash %0h, required none", bus.hash_slot, bus.hash_out);
                    end else begin
                        e = sbq.pop_front();
                        check("hash_value", bus.hash_out, e.hash);
                        check("hash_slot", 64'(bus.hash_slot), 64'(e.slot));
                        if (e.when >= 0) check("hash_cycle", 64'(cyc), 64'(e.when));
                    end
                end else begin
                    hold  = 1'b1;
                    ph    = bus.hash_out;
                    pslot = bus.hash_slot;
                end
            end else begin
                hold = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        longint ls, ls2, r;
        bus.key56_in  = '0;
        bus.key_valid = 1'b0;
        bus.salt_in   = '0;
        bus.hash_rdy  = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk_reset("rst");
        RESET_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        // Full batch, fixed salt.
        run_batch(16'hFFFF, 56'h11_2233_4455_6600, 12'h3A5, 1'b1, ls);
        wait_cyc(ls + 415);
        check("t1_busy_415", 64'(bus.busy), 1);
        wait_cyc(ls + 416);
        check("t1_busy_416", 64'(bus.busy), 0);
        check("t1_enable_416", 64'(bus.ENABLE_CRYPT), 0);
        wait_cyc(ls + 420);
        check("t1_drained", 64'(sbq.size()), 0);

        // Sparse batch: slots 0, 5, 15 only.
        run_batch(16'h8021, 56'hA0_0000_0000_1000, 12'h0F0, 1'b1, ls);
        wait_cyc(ls + 420);
        check("t2_drained", 64'(sbq.size()), 0);
        check("t2_hash_valid", 64'(bus.hash_valid), 0);

        // Continuous keys, constant salt: second LOAD overlaps the window.
        run_batch(16'hFFFF, 56'h30_0000_0000_0000, 12'h555, 1'b1, ls);
        run_batch(16'hFFFF, 56'h31_0000_0000_0000, 12'h555, 1'b1, ls2);
        check("t3_period", 64'(ls2 - ls), 64'(L));
        wait_cyc(ls2 + 420);
        check("t3_drained", 64'(sbq.size()), 0);

        // Salt changes for the next batch: no overlap.
        run_batch(16'hFFFF, 56'h50_0000_0000_0000, 12'h123, 1'b1, ls);
        fork
            begin
                wait_cyc(ls + 415);
                check("t4_salt_held", 64'(bus.core_salt), 64'h123);
            end
            run_batch(16'hFFFF, 56'h60_0000_0000_0000, 12'h456, 1'b1, ls2);
        join
        check("t4_no_overlap", 64'(ls2 - ls >= 417), 1);
        check("t4_new_salt", 64'(bus.core_salt), 64'h456);
        wait_cyc(ls2 + 420);
        check("t4_drained", 64'(sbq.size()), 0);

        // Output stalled: FIFO fills and the next batch waits in IDLE.
        bus.hash_rdy = 1'b0;
        run_batch(16'hFFFF, 56'h70_0000_0000_0000, 12'h789, 1'b0, ls);
        wait_cyc(ls + 420);
        check("t5_busy", 64'(bus.busy), 0);
        check("t5_hash_valid", 64'(bus.hash_valid), 1);
        check("t5_head_slot", 64'(bus.hash_slot), 0);
        check("t5_head_hash", bus.hash_out, hfun(56'h70_0000_0000_0000, 12'h789));
        r = 0;
        fork
            begin
                repeat (10) begin
                    @(posedge CLK);
                    #1;
                end
                check("t5_wait_key_rdy", 64'(bus.key_rdy), 0);
                check("t5_wait_busy", 64'(bus.busy), 0);
                bus.hash_rdy = 1'b1;
                r = cyc;
            end
            run_batch(16'hFFFF, 56'h80_0000_0000_0000, 12'h789, 1'b1, ls2);
        join
        check("t5_restart", 64'(ls2 - r), 17);
        wait_cyc(ls2 + 420);
        check("t5_drained", 64'(sbq.size()), 0);

        // Reset in the middle of a batch, then a clean batch.
        run_batch(16'hFFFF, 56'h90_0000_0000_0000, 12'hABC, 1'b1, ls);
        wait_cyc(ls + 200);
        RESET_N = 1'b0;
        #1;
        chk_reset("midrst");
        sbq.delete();
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("midrst_hash_valid", 64'(bus.hash_valid), 0);
        run_batch(16'hFFFF, 56'hC0_0000_0000_0000, 12'hDEF, 1'b1, ls);
        wait_cyc(ls + 420);
        check("t6_drained", 64'(sbq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
